adaptive_bias_ctrl: RTL

ADAPTIVE_BIAS_CTRL -- requirements
Module: adaptive_bias_ctrl

---
 rtl/adaptive_bias_ctrl_pkg.sv | 23 ++
 rtl/adaptive_bias_ctrl_if.sv | 22 ++
 rtl/adaptive_bias_ctrl_sync.sv | 19 +
 rtl/adaptive_bias_ctrl.sv | 113 +++++++++++
 4 files changed

// File: rtl/adaptive_bias_ctrl_pkg.sv
// Shared types and default constants for the adaptive OTA bias controller.
package adaptive_bias_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_BOOST = 2'd2,
        ST_HOLD  = 2'd3
    } bias_state_e;

    localparam int DEF_WIDTH      = 6;
    localparam int DEF_CODE_MIN   = 4;
    localparam int DEF_CODE_MAX   = 56;
    localparam int DEF_BOOST_STEP = 8;
    localparam int DEF_HOLD_CYC   = 16;
    localparam int DEF_DECAY_DIV  = 8;

    // Bits needed for a counter that runs 0..n-1 (never narrower than one bit).
    function automatic int cnt_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adaptive_bias_ctrl_if.sv
// Control/status bundle between the bias controller and its host.
interface adaptive_bias_ctrl_if
    import adaptive_bias_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             en;
    logic             slew_det;
    logic [WIDTH-1:0] vd_code;
    logic             code_vld;
    logic [1:0]       state_o;

    modport master (
        output en, slew_det,
        input  vd_code, code_vld, state_o
    );

    modport slave (
        input  en, slew_det,
        output vd_code, code_vld, state_o
    );
endinterface

// File: rtl/adaptive_bias_ctrl_sync.sv
// Two-flop synchronizer for the asynchronous slew comparator output.
module bias_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/adaptive_bias_ctrl.sv
// Dynamic-bias controller: boosts the DAC code while the OTA slews, holds it
// briefly once slewing ends, then decays it back toward the quiescent floor.
module adaptive_bias_ctrl
    import adaptive_bias_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int CODE_MIN   = DEF_CODE_MIN,
    parameter int CODE_MAX   = DEF_CODE_MAX,
    parameter int BOOST_STEP = DEF_BOOST_STEP,
    parameter int HOLD_CYC   = DEF_HOLD_CYC,
    parameter int DECAY_DIV  = DEF_DECAY_DIV
) (
    input logic                 clk,
    input logic                 rst,
    adaptive_bias_ctrl_if.slave bus
);
    localparam int DW = cnt_bits(DECAY_DIV);
    localparam int HW = cnt_bits(HOLD_CYC);

    localparam logic [WIDTH:0]   MIN_X  = (WIDTH+1)'(CODE_MIN);
    localparam logic [WIDTH:0]   MAX_X  = (WIDTH+1)'(CODE_MAX);
    localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(BOOST_STEP);
    localparam logic [WIDTH-1:0] MIN_W  = WIDTH'(CODE_MIN);
    localparam logic [DW-1:0]    DCNT_LAST = DW'(DECAY_DIV - 1);
    localparam logic [HW-1:0]    HCNT_LAST = HW'(HOLD_CYC - 1);

    bias_state_e      state;
    logic [WIDTH-1:0] code;
    logic             vld;
    logic [DW-1:0]    dcnt;
    logic [HW-1:0]    hcnt;
    logic             sd_s;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] inc_code;
    logic [WIDTH-1:0] dec_code;

    bias_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.slew_det),
        .q   (sd_s)
    );

    // The extra carry bit lets a sum past 2^WIDTH still clamp to CODE_MAX.
    // NOTE: each always_comb output is assigned on every path, so no latch is inferred.
    always_comb begin
        sum      = {1'b0, code} + STEP_X;
        inc_code = (sum > MAX_X) ? MAX_X[WIDTH-1:0] : sum[WIDTH-1:0];
        dec_code = ({1'b0, code} > MIN_X) ? code - WIDTH'(1) : code;
    end

    // NOTE: state uses non-blocking assignments so every branch reads pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            code  <= MIN_W;
            vld   <= 1'b0;
            dcnt  <= '0;
            hcnt  <= '0;
        end else if (!bus.en) begin
            state <= ST_IDLE;
            code  <= MIN_W;
            vld   <= (code != MIN_W);
        end else begin
            vld <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    state <= ST_TRACK;
                    dcnt  <= '0;
                end
                ST_TRACK: begin
                    if (sd_s) begin
                        state <= ST_BOOST;
                        code  <= inc_code;
                        vld   <= (inc_code != code);
                    end else if (dcnt == DCNT_LAST) begin
                        dcnt <= '0;
                        code <= dec_code;
                        vld  <= (dec_code != code);
                    end else begin
                        dcnt <= dcnt + DW'(1);
                    end
                end
                ST_BOOST: begin
                    if (sd_s) begin
                        code <= inc_code;
                        vld  <= (inc_code != code);
                    end else begin
                        state <= ST_HOLD;
                        hcnt  <= '0;
                    end
                end
                ST_HOLD: begin
                    if (sd_s) begin
                        state <= ST_BOOST;
                        code  <= inc_code;
                        vld   <= (inc_code != code);
                    end else if (hcnt == HCNT_LAST) begin
                        state <= ST_TRACK;
                        dcnt  <= '0;
                    end else begin
                        hcnt <= hcnt + HW'(1);
                    end
                end
            endcase
        end
    end

    assign bus.vd_code  = code;
    assign bus.code_vld = vld;
    assign bus.state_o  = state;
endmodule
